// File: rtl/mmio_requester.sv
// Host-side CCI-P MMIO initiator: issues one read or write at a time toward an AFU
// and matches the read response by TID, reporting timeout and TID-mismatch errors.
module mmio_requester #(
    parameter int TIMEOUT = 64,
    parameter int TID_W   = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_write,
    input  logic [15:0]      cmd_addr,
    input  logic [63:0]      cmd_data,
    output logic             mmio_wr_valid,
    output logic             mmio_rd_valid,
    output logic [15:0]      mmio_addr,
    output logic [TID_W-1:0] mmio_tid,
    output logic [63:0]      mmio_data,
    input  logic             rsp_valid,
    input  logic [TID_W-1:0] rsp_tid,
    input  logic [63:0]      rsp_data,
    output logic             done,
    output logic             done_write,
    output logic [63:0]      rd_data,
    output logic             err_timeout,
    output logic             err_tid,
    output logic [7:0]       stray_cnt,
    output logic [1:0]       dbg_state
);
    // Command handshake: a command transfers on a rising edge where cmd_valid and
    // cmd_ready are both high; cmd_ready is registered and only high in IDLE.

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t            state;
    logic [TID_W-1:0]  tid;
    logic [CNT_W-1:0]  cnt;

    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            tid           <= '0;
            cnt           <= '0;
            cmd_ready     <= 1'b0;
            mmio_wr_valid <= 1'b0;
            mmio_rd_valid <= 1'b0;
            mmio_addr     <= '0;
            mmio_tid      <= '0;
            mmio_data     <= '0;
            done          <= 1'b0;
            done_write    <= 1'b0;
            rd_data       <= '0;
            err_timeout   <= 1'b0;
            err_tid       <= 1'b0;
            stray_cnt     <= '0;
        end else begin
            // Request fields and completion flags are single-cycle; zero unless set below.
            mmio_wr_valid <= 1'b0;
            mmio_rd_valid <= 1'b0;
            mmio_addr     <= '0;
            mmio_tid      <= '0;
            mmio_data     <= '0;
            done          <= 1'b0;
            done_write    <= 1'b0;
            err_timeout   <= 1'b0;
            err_tid       <= 1'b0;

            if (rsp_valid && state != WAIT && stray_cnt != 8'hFF)
                stray_cnt <= stray_cnt + 8'd1;

            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready     <= 1'b0;
                        mmio_wr_valid <= cmd_write;
                        mmio_rd_valid <= !cmd_write;
                        mmio_addr     <= cmd_addr;
                        mmio_tid      <= tid;
                        mmio_data     <= cmd_write ? cmd_data : 64'd0;
                        // Writes are posted: completion coincides with the request pulse.
                        done          <= cmd_write;
                        done_write    <= cmd_write;
                        state         <= ISSUE;
                    end else begin
                        cmd_ready <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (mmio_wr_valid) begin
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        cnt   <= '0;
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (rsp_valid) begin
                        rd_data   <= rsp_data;
                        err_tid   <= (rsp_tid != tid);
                        done      <= 1'b1;
                        tid       <= tid + 1'b1;
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end else if (cnt == CNT_LAST) begin
                        rd_data     <= '0;
                        err_timeout <= 1'b1;
                        done        <= 1'b1;
                        tid         <= tid + 1'b1;
                        cmd_ready   <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mmio_requester.sv
// Randomized bench for mmio_requester: the bench plays the AFU (register map plus
// DFH/ID constants) and predicts TIDs, read data, errors and stray counts.
module tb_mmio_requester;
    localparam int TIMEOUT = 64;
    localparam int TID_W   = 9;
    localparam logic [63:0] DFH     = 64'h1000_0100_0000_0000;
    localparam logic [63:0] ID_LO   = 64'h8899_AABB_CCDD_EEFF;
    localparam logic [63:0] ID_HI   = 64'h0011_2233_4455_6677;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic             cmd_write = 1'b0;
    logic [15:0]      cmd_addr = '0;
    logic [63:0]      cmd_data = '0;
    logic             mmio_wr_valid;
    logic             mmio_rd_valid;
    logic [15:0]      mmio_addr;
    logic [TID_W-1:0] mmio_tid;
    logic [63:0]      mmio_data;
    logic             rsp_valid = 1'b0;
    logic [TID_W-1:0] rsp_tid = '0;
    logic [63:0]      rsp_data = '0;
    logic             done;
    logic             done_write;
    logic [63:0]      rd_data;
    logic             err_timeout;
    logic             err_tid;
    logic [7:0]       stray_cnt;
    logic [1:0]       dbg_state;

    mmio_requester #(.TIMEOUT(TIMEOUT), .TID_W(TID_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data),
        .mmio_wr_valid(mmio_wr_valid), .mmio_rd_valid(mmio_rd_valid),
        .mmio_addr(mmio_addr), .mmio_tid(mmio_tid), .mmio_data(mmio_data),
        .rsp_valid(rsp_valid), .rsp_tid(rsp_tid), .rsp_data(rsp_data),
        .done(done), .done_write(done_write), .rd_data(rd_data),
        .err_timeout(err_timeout), .err_tid(err_tid), .stray_cnt(stray_cnt),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    // Reference state
    int               n_checks = 0;
    int               n_errors = 0;
    logic [63:0]      regs[int];
    logic [TID_W-1:0] exp_tid = '0;
    logic [63:0]      exp_rd = '0;
    int               exp_stray = 0;
    logic [63:0]      exp_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] afu_value(input int a);
        if (regs.exists(a)) return regs[a];
        return 64'd0;
    endfunction

    task automatic wait_ready();
        int k = 0;
        while (!cmd_ready && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("cmd_ready_wait", {63'd0, cmd_ready}, 64'd1);
    endtask

    task automatic do_write(input logic [15:0] a, input logic [63:0] d);
        wait_ready();
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = a; cmd_data = d;
        @(negedge clk);
        cmd_valid = 1'b0;
        check("wr_flags", {57'd0, mmio_wr_valid, mmio_rd_valid, done, done_write,
              err_timeout, err_tid, cmd_ready}, {57'd0, 7'b1011000});
        check("wr_addr", {48'd0, mmio_addr}, {48'd0, a});
        check("wr_data", mmio_data, d);
        check("wr_tid", {55'd0, mmio_tid}, {55'd0, exp_tid});
        check("wr_rd_hold", rd_data, exp_rd);
        regs[int'(a)] = d;
        @(negedge clk);
        check("wr_after", {61'd0, mmio_wr_valid, done, cmd_ready}, {61'd0, 3'b001});
    endtask

    // mode 0: correct TID, 1: wrong TID, 2: silent responder
    task automatic do_read(input logic [15:0] a, input int lat, input int mode);
        logic [63:0] v;
        logic        early;
        int          cnt;
        v = afu_value(int'(a));
        early = 1'b0;
        wait_ready();
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = a;
        cmd_data = {$urandom, $urandom};
        @(negedge clk);
        cmd_valid = 1'b0;
        check("rd_flags", {60'd0, mmio_wr_valid, mmio_rd_valid, done, cmd_ready}, {60'd0, 4'b0100});
        check("rd_addr", {48'd0, mmio_addr}, {48'd0, a});
        check("rd_tid", {55'd0, mmio_tid}, {55'd0, exp_tid});
        check("rd_data_zero", mmio_data, 64'd0);
        if (mode == 2) begin
            cnt = 0;
            while (!done && cnt < TIMEOUT + 20) begin
                @(negedge clk);
                cnt++;
            end
            check("to_latency", 64'(cnt), 64'(TIMEOUT + 1));
            check("to_flags", {59'd0, done, done_write, err_timeout, err_tid, cmd_ready},
                  {59'd0, 5'b10101});
            exp_rd = 64'd0;
        end else begin
            repeat (lat) begin
                @(negedge clk);
                early |= done;
            end
            rsp_valid = 1'b1;
            rsp_tid   = (mode == 1) ? exp_tid + TID_W'(2) : exp_tid;
            rsp_data  = v;
            @(negedge clk);
            rsp_valid = 1'b0;
            check("rd_no_early_done", {63'd0, early}, 64'd0);
            check("rd_flags_done", {59'd0, done, done_write, err_timeout, err_tid, cmd_ready},
                  {59'd0, 1'b1, 1'b0, 1'b0, (mode == 1), 1'b1});
            exp_rd = v;
        end
        exp_q.push_back(exp_rd);
        check("rd_data", rd_data, exp_q.pop_front());
        exp_tid = exp_tid + 1'b1;
    endtask

    initial begin
        logic        done_seen;
        logic [15:0] a;
        regs[0] = DFH;
        regs[2] = ID_LO;
        regs[4] = ID_HI;

        // Reset state
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_flags", {57'd0, cmd_ready, mmio_wr_valid, mmio_rd_valid, done, done_write,
              err_timeout, err_tid}, 64'd0);
        check("rst_bus", {mmio_addr, 7'd0, mmio_tid, 32'd0} ^ mmio_data, 64'd0);
        check("rst_rd_data", rd_data, 64'd0);
        check("rst_stray", {56'd0, stray_cnt}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_rst", {63'd0, cmd_ready}, 64'd1);

        // Register write then read back
        do_write(16'h0020, 64'hDEADBEEF_CAFEF00D);
        do_read(16'h0020, 1, 0);

        // DFH and AFU ID reads
        do_read(16'h0000, 2, 0);
        check("dfh_type", {60'd0, rd_data[63:60]}, 64'd1);
        check("dfh_eol", {63'd0, rd_data[40]}, 64'd1);
        do_read(16'h0002, 3, 0);
        do_read(16'h0004, 1, 0);

        // Random mix
        for (int i = 0; i < 40; i++) begin
            a = 16'($urandom_range(8, 15) * 4);
            if ($urandom_range(0, 1) == 1)
                do_write(a, {$urandom, $urandom});
            else
                do_read(a, $urandom_range(1, 6), ($urandom_range(0, 4) == 0) ? 1 : 0);
        end

        // Timeout, then the following read carries the next TID
        do_read(16'h0020, 0, 2);
        do_read(16'h0020, 2, 0);
        do_read(16'h0024, 1, 1);

        // Responses on the last and second-to-last timeout cycles
        do_read(16'h0020, TIMEOUT, 0);
        do_read(16'h0002, TIMEOUT - 1, 0);

        // Stray responses saturate
        rsp_valid = 1'b1;
        repeat (300) @(negedge clk);
        rsp_valid = 1'b0;
        exp_stray = (exp_stray + 300 > 255) ? 255 : exp_stray + 300;
        check("stray_sat", {56'd0, stray_cnt}, 64'(exp_stray));

        // TID wrap over 512 reads
        for (int i = 0; i < 512; i++)
            do_read(16'($urandom_range(0, 2) * 2), 1, 0);
        check("tid_wrap_stray", {56'd0, stray_cnt}, 64'(exp_stray));

        // Reset in WAIT aborts without a done pulse
        wait_ready();
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 16'h0020;
        @(negedge clk);
        cmd_valid = 1'b0;
        done_seen = 1'b0;
        repeat (5) begin
            @(negedge clk);
            done_seen |= done;
        end
        rst_n = 1'b0;
        repeat (3) begin
            @(negedge clk);
            done_seen |= done;
        end
        check("rst_mid_ready", {63'd0, cmd_ready}, 64'd0);
        check("rst_mid_stray", {56'd0, stray_cnt}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        done_seen |= done;
        check("rst_mid_ready_rel", {63'd0, cmd_ready}, 64'd1);
        check("rst_mid_no_done", {63'd0, done_seen}, 64'd0);
        rsp_valid = 1'b1;
        rsp_tid   = exp_tid;
        @(negedge clk);
        rsp_valid = 1'b0;
        @(negedge clk);
        check("late_rsp_stray", {56'd0, stray_cnt}, 64'd1);
        exp_tid = '0;
        exp_rd  = 64'd0;
        check("rst_mid_rd_data", rd_data, exp_rd);
        do_read(16'h0020, 2, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/mmio_requester.md
# mmio_requester

Host-side MMIO initiator for the CCI-P MMIO path: accepts single read/write commands, drives the MMIO request signals (write-valid, read-valid, address, TID, data) toward an AFU, and matches read responses on the AFU's read-response channel by TID. Used as the driver/checker end in bench and loopback builds so AFU MMIO register logic is exercised without the host stack. One transaction outstanding at a time, with timeout and TID-mismatch reporting.

## Interface
Parameters:
- TIMEOUT, 64: WAIT-state cycles before a read is abandoned (≥2).
- TID_W, 9: TID width.

Ports:
- clk  in  1  single clock; everything is rising-edge.
- rst_n  in  1  reset, synchronous, active-low.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  block can accept a command.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  16  MMIO address (32-bit word units, as in the CCI-P MMIO header).
- cmd_data  in  64  write data; ignored for reads.
- mmio_wr_valid  out  1  one-cycle write request pulse.
- mmio_rd_valid  out  1  one-cycle read request pulse.
- mmio_addr  out  16  request address.
- mmio_tid  out  TID_W  request TID.
- mmio_data  out  64  request data; 0 on reads.
- rsp_valid  in  1  AFU read-response valid.
- rsp_tid  in  TID_W  response TID.
- rsp_data  in  64  response data.
- done  out  1  one-cycle completion pulse.
- done_write  out  1  qualifies done: 1 = write completion.
- rd_data  out  64  read result, held until next done.
- err_timeout  out  1  with done: read timed out.
- err_tid  out  1  with done: response TID mismatched.
- stray_cnt  out  8  saturating count of rsp_valid seen outside WAIT.

## Operation
- States: IDLE, ISSUE, WAIT.
- IDLE: cmd_ready=1. On cmd_valid: latch write, addr, data (data forced to 0 for reads); go ISSUE.
- ISSUE (one cycle): assert mmio_wr_valid or mmio_rd_valid. mmio_addr, mmio_tid, mmio_data valid this cycle, 0 otherwise.
  - Write: done=1, done_write=1; go IDLE. TID not incremented.
  - Read: clear timeout counter; go WAIT.
- WAIT: counter increments each cycle.
  - rsp_valid with rsp_tid == issued TID: rd_data<=rsp_data, err flags 0.
  - rsp_valid with other TID: rd_data<=rsp_data, err_tid=1.
  - No rsp_valid and counter reaches TIMEOUT-1: rd_data<=0, err_timeout=1.
  - Any of these: done pulse next cycle, done_write=0, TID += 1 (wraps 2^TID_W-1 -> 0), go IDLE.
  - rsp_valid on the final timeout cycle counts as a response, not a timeout.
- rsp_valid in IDLE or ISSUE: stray_cnt += 1, saturate at 255; no other effect.
- err_* and done_write are valid only with done; otherwise 0.

## Timing
- Reset (rst_n low at a rising edge): state IDLE, TID 0, stray_cnt 0, rd_data 0, all pulses and errors 0. cmd_ready is 0 while rst_n is low; it becomes 1 in the first cycle after release.
- Reset asserted mid-transaction aborts the transaction with no done pulse. A late response afterwards counts as stray.
- Accept at edge T (cmd_valid & cmd_ready): request pulse in cycle T+1. cmd_ready is low from T+1 until the state returns to IDLE.
- Write: done in T+1, same cycle as mmio_wr_valid. Next accept possible at edge T+2.
- Read: response sampled in cycle R (R ≥ T+2) gives done and rd_data in R+1, and cmd_ready in R+1.
- Timeout with no response: done in cycle T+2+TIMEOUT.
- Throughput: writes 1 per 2 cycles; reads 1 per (response latency + 2) cycles.

## Test plan
- Write then read against an AFU with a register at 0x0020: write 0x0020 = 0xDEADBEEF_CAFEF00D, then read 0x0020 -> mmio_wr_valid one cycle; read done with rd_data 0xDEADBEEF_CAFEF00D, tid 0, no errors.
- DFH read at 0x0000 -> rd_data[63:60]=4'b0001 and bit 40 set; reads at 0x0002/0x0004 return the AFU ID halves. TIDs are 0, 1, 2.
- Silent responder, TIMEOUT=64 -> done exactly 66 cycles after accept, with err_timeout=1 and rd_data=0; the next read uses tid+1.
- Responder returns TID 5 when TID 3 was issued -> done with err_tid=1 and rd_data = the returned data.
- Response on the last timeout cycle -> no timeout. rsp_valid in IDLE 300 times -> stray_cnt=255.
- 512 reads -> TID wraps 511 -> 0. Reset dropped during WAIT -> no done pulse, TID 0, cmd_ready 1 one cycle after release.
